// File: rtl/ufi_bus_arbiter_pkg.sv
// Shared definitions for the UFI bus arbiter: idle-bus bit values and the clog2 helper.
package ufi_bus_arbiter_pkg;

  localparam logic UFI_IDLE_DAT_BIT  = 1'b0;
  localparam logic UFI_IDLE_ADRS_BIT = 1'b1;
  localparam logic UFI_IDLE_OWNER_BIT = 1'b1;

  function automatic int ufi_clog2(input int value);
    int width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/ufi_id_fifo.sv
// In-order channel-tag store for outstanding reads; head is readable combinationally.
// almost_full is registered from the next count; the caller gates push at depth and pop at empty.
module ufi_id_fifo
  import ufi_bus_arbiter_pkg::*;
#(
  parameter int pIdBit       = 2,
  parameter int pIdFifoDepth = 16,
  localparam int PTR_BIT     = ufi_clog2(pIdFifoDepth),
  localparam int CNT_BIT     = PTR_BIT + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [pIdBit-1:0]  push_dat,
  input  logic               pop,
  output logic [pIdBit-1:0]  head_dat,
  output logic [CNT_BIT-1:0] count,
  output logic               almost_full,
  output logic               empty
);

  localparam logic [CNT_BIT-1:0] AFULL_CNT = CNT_BIT'(pIdFifoDepth - 2);

  logic [pIdBit-1:0]  mem [pIdFifoDepth];
  logic [PTR_BIT-1:0] wr_ptr, rd_ptr;
  logic [CNT_BIT-1:0] count_nxt;

  assign empty     = (count == '0);
  assign head_dat  = mem[rd_ptr];
  assign count_nxt = count + CNT_BIT'(push) - CNT_BIT'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BIT'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BIT'(1);
      count       <= count_nxt;
      almost_full <= (count_nxt >= AFULL_CNT);
    end
  end

endmodule

// File: rtl/ufi_bus_arbiter.sv
// Arbitrates pChNum UFI masters onto one slave port (strict priority low channels, burst-held RR rest);
// slave port is registered one edge after the strobe; grants drop while the read-tag FIFO is almost full.
module ufi_bus_arbiter
  import ufi_bus_arbiter_pkg::*;
#(
  parameter int pChNum        = 4,
  parameter int pFixedPrioNum = 2,
  parameter int pUfiBusWidth  = 8,
  parameter int pBusAdrsBit   = 32,
  parameter int pIdFifoDepth  = 16,
  localparam int pIdBit       = ufi_clog2(pChNum)
) (
  input  logic                             iUfiClk,
  input  logic                             iUfiRst,
  input  logic [pChNum*pUfiBusWidth-1:0]   iMUfiWd,
  input  logic [pChNum*pBusAdrsBit-1:0]    iMUfiAdrs,
  input  logic [pChNum-1:0]                iMUfiWEd,
  input  logic [pChNum-1:0]                iMUfiREd,
  input  logic [pChNum-1:0]                iMUfiVd,
  input  logic [pChNum-1:0]                iMUfiCmd,
  output logic [pChNum-1:0]                oMUfiGnt,
  output logic [pUfiBusWidth-1:0]          oMUfiRd,
  output logic [pChNum-1:0]                oMUfiEdd,
  output logic                             oMUfiRdy,
  output logic [pUfiBusWidth-1:0]          oSUfiWd,
  output logic [pBusAdrsBit-1:0]           oSUfiAdrs,
  output logic                             oSUfiWEd,
  output logic                             oSUfiREd,
  output logic                             oSUfiCmd,
  input  logic [pUfiBusWidth-1:0]          iSUfiRd,
  input  logic                             iSUfiREd,
  input  logic                             iSUfiRdy,
  output logic                             oUfiIdFifoFull,
  output logic                             oUfiErrOrphan
);

  localparam int CNT_BIT = ufi_clog2(pIdFifoDepth) + 1;

  typedef logic [pIdBit:0] owner_t;

  localparam owner_t                  IDLE_OWNER = {(pIdBit+1){UFI_IDLE_OWNER_BIT}};
  localparam logic [pChNum-1:0]       FIX_MASK   = pChNum'((1 << pFixedPrioNum) - 1);
  localparam logic [CNT_BIT-1:0]      TAG_MAX    = CNT_BIT'(pIdFifoDepth);
  localparam logic [pIdBit-1:0]       RR_PTR_RST = pIdBit'(pChNum - 1);

  owner_t             owner, owner_nxt;
  logic [pIdBit-1:0]  owner_ch, rr_ptr, rr_ptr_nxt, tag_head;
  logic [pChNum-1:0]  fix_req, rr_req;
  logic [CNT_BIT-1:0] tag_cnt;
  logic               fwd, tag_push, tag_pop, tag_empty;

  // IDLE is all ones, so the owner MSB alone marks the bus as unowned.
  assign owner_ch = owner[pIdBit-1:0];
  assign fix_req  = iMUfiVd & FIX_MASK;
  assign rr_req   = iMUfiVd & ~FIX_MASK;
  assign fwd      = ~owner[pIdBit] & ~oUfiIdFifoFull;
  assign tag_push = fwd & iMUfiREd[owner_ch] & (tag_cnt != TAG_MAX);
  assign tag_pop  = iSUfiREd & ~tag_empty;

  always_comb begin
    bit found;
    int idx;
    owner_nxt  = IDLE_OWNER;
    rr_ptr_nxt = rr_ptr;
    found      = 1'b0;
    idx        = 0;
    for (int c = pChNum - 1; c >= 0; c--) begin
      if (fix_req[c]) begin
        owner_nxt = owner_t'(c);
        found     = 1'b1;
      end
    end
    if (!found && !owner[pIdBit] && rr_req[owner_ch]) begin
      owner_nxt = owner;
      found     = 1'b1;
    end
    for (int k = 1; k <= pChNum; k++) begin
      idx = (int'(rr_ptr) + k) % pChNum;
      if (!found && rr_req[idx]) begin
        owner_nxt  = owner_t'(idx);
        rr_ptr_nxt = pIdBit'(idx);
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    oMUfiGnt = '0;
    if (fwd) oMUfiGnt[owner_ch] = 1'b1;
  end

  // Forwarding uses the pre-edge owner, so a preempted owner's last granted strobe still goes out.
  always_ff @(posedge iUfiClk) begin
    if (!iUfiRst) begin
      owner         <= IDLE_OWNER;
      rr_ptr        <= RR_PTR_RST;
      oSUfiWd       <= {pUfiBusWidth{UFI_IDLE_DAT_BIT}};
      oSUfiAdrs     <= {pBusAdrsBit{UFI_IDLE_ADRS_BIT}};
      oSUfiWEd      <= 1'b0;
      oSUfiREd      <= 1'b0;
      oSUfiCmd      <= 1'b0;
      oMUfiEdd      <= '0;
      oMUfiRd       <= '0;
      oMUfiRdy      <= 1'b0;
      oUfiErrOrphan <= 1'b0;
    end else begin
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      if (fwd) begin
        oSUfiWd   <= iMUfiWd[int'(owner_ch)*pUfiBusWidth +: pUfiBusWidth];
        oSUfiAdrs <= iMUfiAdrs[int'(owner_ch)*pBusAdrsBit +: pBusAdrsBit];
        oSUfiWEd  <= iMUfiWEd[owner_ch];
        oSUfiREd  <= iMUfiREd[owner_ch];
        oSUfiCmd  <= iMUfiCmd[owner_ch];
      end else begin
        oSUfiWd   <= {pUfiBusWidth{UFI_IDLE_DAT_BIT}};
        oSUfiAdrs <= {pBusAdrsBit{UFI_IDLE_ADRS_BIT}};
        oSUfiWEd  <= 1'b0;
        oSUfiREd  <= 1'b0;
        oSUfiCmd  <= 1'b0;
      end
      oMUfiRd  <= iSUfiRd;
      oMUfiRdy <= iSUfiRdy;
      oMUfiEdd <= tag_pop ? (pChNum'(1) << tag_head) : '0;
      if (iSUfiREd && tag_empty) oUfiErrOrphan <= 1'b1;
    end
  end

  ufi_id_fifo #(
    .pIdBit       (pIdBit),
    .pIdFifoDepth (pIdFifoDepth)
  ) u_id_fifo (
    .clk         (iUfiClk),
    .rst_n       (iUfiRst),
    .push        (tag_push),
    .push_dat    (owner_ch),
    .pop         (tag_pop),
    .head_dat    (tag_head),
    .count       (tag_cnt),
    .almost_full (oUfiIdFifoFull),
    .empty       (tag_empty)
  );

endmodule
